// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI link types and defaults
package spi_pkg;

  // Frame state of the responder
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_SS = 2'd2
  } state_t;

  // Frame length shared with the SPI master
  localparam int          FRAME_BITS_DEFAULT = 32;
  // Word returned to the master when nothing fresh was staged
  localparam logic [31:0] FILL_WORD_DEFAULT  = 32'hFFFF_FFFF;
  // Width of the received-bit counter (covers up to 32 bits)
  localparam int          CNT_W              = 6;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage synchroniser with rise/fall strobes
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   hist;

  // Shift the raw pin through the chain; hist holds the previous synchronised level
  always_ff @(posedge clock) begin
    if (reset) begin
      chain <= {SYNC_STAGES{RESET_VALUE}};
      hist  <= RESET_VALUE;
    end else begin
      chain[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      hist <= chain[SYNC_STAGES-1];
    end
  end

  assign rise = chain[SYNC_STAGES-1] & ~hist;
  assign fall = ~chain[SYNC_STAGES-1] & hist;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI responder top; SPI_SLAVE_FRAME_ERR_EN adds frame_err and err_cnt
module spi_slave
  import spi_pkg::*;
#(
  parameter int          FRAME_BITS  = FRAME_BITS_DEFAULT,
  parameter logic [31:0] FILL_WORD   = FILL_WORD_DEFAULT,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_transmit,
  input  logic        tx_load,
  input  logic        mlb,
  output logic [31:0] data_received,
  output logic        done,
  output logic        busy,
  output logic        underrun,
`ifdef SPI_SLAVE_FRAME_ERR_EN
  output logic        frame_err,
  output logic [7:0]  err_cnt,
`endif
  input  logic        sclk,
  input  logic        ss,
  input  logic        din,
  output logic        dout
);

  logic sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic [SYNC_STAGES-1:0] din_chain;
  logic din_s;

  state_t                state;
  logic [FRAME_BITS-1:0] tx_sr, rx_sr;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  mlb_q;
  logic [31:0]           shadow, tx_word, rx_ext;
  logic                  fresh, frame_start;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sclk_sync (
    .clock(clock), .reset(reset), .raw(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  // ss chain resets low so a reset taken while ss is held low cannot fabricate a falling edge
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_ss_sync (
    .clock(clock), .reset(reset), .raw(ss), .rise(ss_rise), .fall(ss_fall)
  );

  // din travels through the same depth as sclk so a sampled bit lines up with its rise strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      din_chain <= '1;
    end else begin
      din_chain[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        din_chain[i] <= din_chain[i-1];
      end
    end
  end

  assign din_s       = din_chain[SYNC_STAGES-1];
  assign tx_word     = fresh ? shadow : FILL_WORD;
  assign frame_start = (state == IDLE) && ss_fall;

  // Zero-extend the received frame into the 32-bit output word
  always_comb begin
    rx_ext = '0;
    rx_ext[FRAME_BITS-1:0] = rx_sr;
  end

  // Frame FSM, shift registers, shadow staging and status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      tx_sr         <= '1;
      rx_sr         <= '1;
      bit_cnt       <= '0;
      mlb_q         <= 1'b1;
      data_received <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
      underrun      <= 1'b0;
      dout          <= 1'b1;
      shadow        <= FILL_WORD;
      fresh         <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err     <= 1'b0;
      err_cnt       <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          dout <= 1'b1;
          if (ss_fall) begin
            tx_sr   <= tx_word[FRAME_BITS-1:0];
            rx_sr   <= '1;
            bit_cnt <= '0;
            mlb_q   <= mlb;
            busy    <= 1'b1;
            dout    <= mlb ? tx_word[FRAME_BITS-1] : tx_word[0];
            fresh   <= 1'b0;
            if (!fresh) underrun <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt == CNT_W'(FRAME_BITS)) begin
            data_received <= rx_ext;
            done          <= 1'b1;
            dout          <= 1'b1;
            busy          <= ~ss_rise;
            state         <= ss_rise ? IDLE : WAIT_SS;
          end else if (ss_rise) begin
            busy  <= 1'b0;
            dout  <= 1'b1;
            state <= IDLE;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
          end else begin
            if (sclk_rise) begin
              rx_sr   <= mlb_q ? {rx_sr[FRAME_BITS-2:0], din_s} : {din_s, rx_sr[FRAME_BITS-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
            if (sclk_fall) begin
              tx_sr <= mlb_q ? {tx_sr[FRAME_BITS-2:0], 1'b1} : {1'b1, tx_sr[FRAME_BITS-1:1]};
              dout  <= mlb_q ? tx_sr[FRAME_BITS-2] : tx_sr[1];
            end
          end
        end
        WAIT_SS: begin
          dout <= 1'b1;
          if (ss_rise) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A load coinciding with frame start is kept for the next frame
      if (tx_load) begin
        shadow <= data_transmit;
        fresh  <= 1'b1;
        if (!(frame_start && !fresh)) underrun <= 1'b0;
      end
    end
  end

endmodule
